// File: rtl/time_uart_tx.sv
// time_uart_tx: 16-deep FIFO feeding a UART 8N1 serializer paced by a 16x baud tick.
// Define TIME_UART_PARITY_EN to insert an even-parity bit (8E1).
module time_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  baud_tick,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  tx,
  output logic                  tx_busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TIME_UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q, overflow_q, tx_q;
  state_t                state_q;
  logic [TW-1:0]         tick_q;
  logic [BW-1:0]         bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
`ifdef TIME_UART_PARITY_EN
  logic                  parity_q;
`endif
  logic                  pop, wr_en, last_tick;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  always_comb begin
    pop = state_q == IDLE && !empty_q;
    wr_en = push && (!full_q || pop);
    count_d = count_q + (ADDR_WIDTH+1)'(wr_en) - (ADDR_WIDTH+1)'(pop);
    last_tick = baud_tick && tick_q == TW'(OVERSAMPLE-1);
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q <= count_d == (ADDR_WIDTH+1)'(DEPTH);
      empty_q <= count_d == '0;
      if (push && full_q && !pop) overflow_q <= 1'b1;
    end
  end
  // Tick counter restarts on every transition since all exits happen on the last tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
`ifdef TIME_UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (state_q != IDLE && baud_tick) tick_q <= last_tick ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          tick_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
`ifdef TIME_UART_PARITY_EN
            parity_q <= ^mem_q[rd_ptr_q];
`endif
            tx_q <= 1'b0;
            state_q <= START;
          end
        end
        START: if (last_tick) begin
          state_q <= DATA;
          bit_idx_q <= '0;
          tx_q <= shift_q[0];
        end
        DATA: if (last_tick) begin
          shift_q <= shift_q >> 1;
          if (bit_idx_q == BW'(DATA_WIDTH-1)) begin
`ifdef TIME_UART_PARITY_EN
            state_q <= PARITY;
            tx_q <= parity_q;
`else
            state_q <= STOP;
            tx_q <= 1'b1;
`endif
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            tx_q <= shift_q[1];
          end
        end
`ifdef TIME_UART_PARITY_EN
        PARITY: if (last_tick) begin
          state_q <= STOP;
          tx_q <= 1'b1;
        end
`endif
        STOP: if (last_tick) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign full = full_q;
  assign empty = empty_q;
  assign overflow = overflow_q;
  assign tx = tx_q;
  assign tx_busy = state_q != IDLE;
endmodule

// File: tb/tb_time_uart_tx.sv
// tb_time_uart_tx: directed bench for time_uart_tx with an independent UART receiver model.
module tb_time_uart_tx;
`ifdef TIME_UART_PARITY_EN
  localparam int NB = 10;
  logic [NB-1:0] exp53 = 10'b1_0_0101_0011;
`else
  localparam int NB = 9;
  logic [NB-1:0] exp53 = 9'b1_0101_0011;
`endif
  logic clk = 0, rst = 1, push = 0, baud_tick = 0;
  logic [7:0] push_data = 0;
  logic full, empty, overflow, tx, tx_busy;
  int n_checks = 0, n_fail = 0, frame_err = 0;
  bit tick_en = 0;
  logic [7:0] rx_q[$];
  logic rxp_q[$];

  time_uart_tx #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .baud_tick(baud_tick),
    .full(full), .empty(empty), .overflow(overflow), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin : tickgen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        baud_tick = div == 3;
        div = (div + 1) % 4;
      end else begin
        baud_tick = 0;
        div = 0;
      end
    end
  end

  // Receiver: after a falling edge, sample each bit 8 ticks into its 16-tick period
  initial begin : rx_mon
    int nt;
    logic [NB-1:0] bits;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        nt = 0;
        bits = '0;
        for (int k = 0; k < NB && !rst; k++) begin
          while (nt < 16*(k+1)+8 && !rst) begin
            @(posedge clk);
            if (baud_tick) nt++;
          end
          #1 bits[k] = tx;
        end
        if (!rst) begin
          rx_q.push_back(bits[7:0]);
          rxp_q.push_back(bits[8]);
          if (bits[NB-1] !== 1'b1) frame_err++;
        end
      end
    end
  end

  task do_reset;
    @(negedge clk);
    tick_en = 0;
    push = 0;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    rx_q.delete();
    rxp_q.delete();
    frame_err = 0;
  endtask

  task test_reset;
    @(negedge clk);
    n_checks++;
    if ({tx, tx_busy, full, empty, overflow} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset_hold: tx,busy,full,empty,ovf=%b expected 10010", {tx, tx_busy, full, empty, overflow});
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx, tx_busy, full, empty, overflow} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset_release: tx,busy,full,empty,ovf=%b expected 10010", {tx, tx_busy, full, empty, overflow});
    end
  endtask

  task test_single;
    logic txs[800];
    logic bs[800];
    int i0, bad;
    do_reset();
    tick_en = 1;
    push = 1;
    push_data = 8'h53;
    @(negedge clk);
    push = 0;
    n_checks++;
    if ({empty, tx} !== 2'b01) begin
      n_fail++;
      $display("FAIL push_latency: empty,tx=%b expected 01", {empty, tx});
    end
    @(negedge clk);
    n_checks++;
    if ({empty, tx, tx_busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL pop_latency: empty,tx,busy=%b expected 101", {empty, tx, tx_busy});
    end
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      txs[i] = tx;
      bs[i] = tx_busy;
    end
    i0 = -1;
    for (int i = 0; i < 800; i++) if (i0 < 0 && txs[i] === 1'b1) i0 = i;
    n_checks++;
    if (i0 < 60 || i0 > 63) begin
      n_fail++;
      $display("FAIL start_len: got %0d clk expected 61..64", i0 + 1);
    end
    if (i0 < 0 || i0 > 63) i0 = 63;
    for (int k = 0; k < NB; k++) begin
      bad = 0;
      for (int j = 0; j < 64; j++) if (txs[i0+64*k+j] !== exp53[k]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL bit_%0d: %0d of 64 samples differ from expected %b", k, bad, exp53[k]);
      end
    end
    bad = 0;
    for (int i = 0; i < i0 + 64*NB; i++) if (bs[i] !== 1'b1) bad++;
    n_checks++;
    if (bad != 0 || bs[i0+64*NB] !== 1'b0 || txs[i0+64*NB] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_window: %0d low samples in frame, busy after=%b tx after=%b expected 0,0,1", bad, bs[i0+64*NB], txs[i0+64*NB]);
    end
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h53) begin
      n_fail++;
      $display("FAIL single_decode: size %0d first %h expected 1 53", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
  endtask

  task test_frames;
    logic [7:0] msg [12];
    bit saw_full;
    int bad;
    msg = '{8'h53, 8'h57, 8'h20, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0A};
    do_reset();
    tick_en = 1;
    saw_full = 0;
    for (int i = 0; i < 12; i++) begin
      push = 1;
      push_data = msg[i];
      @(negedge clk);
      saw_full |= full;
    end
    push = 0;
    for (int c = 0; c < 9000 && rx_q.size() < 12; c++) begin
      @(negedge clk);
      saw_full |= full;
    end
    repeat (100) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 12; i++) if (i >= rx_q.size() || rx_q[i] !== msg[i]) bad++;
    n_checks++;
    if (rx_q.size() != 12 || bad != 0) begin
      n_fail++;
      $display("FAIL frames_order: got %0d frames with %0d wrong bytes expected 12 and 0", rx_q.size(), bad);
    end
    n_checks++;
    if (saw_full !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frames_flags: saw_full=%b ovf=%b empty=%b busy=%b expected 0 0 1 0", saw_full, overflow, empty, tx_busy);
    end
    n_checks++;
    if (frame_err != 0) begin
      n_fail++;
      $display("FAIL frames_stop: %0d bad stop bits expected 0", frame_err);
    end
  endtask

  task test_overflow;
    int bad;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push = 1;
      push_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    push = 0;
    n_checks++;
    if ({full, empty, overflow, tx_busy} !== 4'b1001) begin
      n_fail++;
      $display("FAIL fill17: full,empty,ovf,busy=%b expected 1001", {full, empty, overflow, tx_busy});
    end
    push = 1;
    push_data = 8'h52;
    @(negedge clk);
    push = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({full, overflow} !== 2'b11) begin
      n_fail++;
      $display("FAIL drop_push: full,ovf=%b expected 11", {full, overflow});
    end
    tick_en = 1;
    for (int c = 0; c < 13000 && rx_q.size() < 17; c++) @(negedge clk);
    repeat (1000) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 17; i++) if (i >= rx_q.size() || rx_q[i] !== 8'h41 + 8'(i)) bad++;
    n_checks++;
    if (rx_q.size() != 17 || bad != 0) begin
      n_fail++;
      $display("FAIL overflow_decode: got %0d frames with %0d wrong bytes expected 17 and 0", rx_q.size(), bad);
    end
    n_checks++;
    if ({overflow, empty, full} !== 3'b110) begin
      n_fail++;
      $display("FAIL overflow_sticky: ovf,empty,full=%b expected 110", {overflow, empty, full});
    end
  endtask

  task test_full_pop;
    int bad, c;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      push = 1;
      push_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    push = 0;
    tick_en = 1;
    for (c = 0; c < 1000 && tx_busy !== 1'b0; c++) @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_idle: busy,full=%b%b expected 01", tx_busy, full);
    end
    push = 1;
    push_data = 8'h7A;
    @(negedge clk);
    push = 0;
    n_checks++;
    if ({full, overflow, tx_busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL push_pop_full: full,ovf,busy=%b expected 101", {full, overflow, tx_busy});
    end
    for (c = 0; c < 13000 && rx_q.size() < 18; c++) @(negedge clk);
    repeat (100) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 17; i++) if (i >= rx_q.size() || rx_q[i] !== 8'h41 + 8'(i)) bad++;
    if (rx_q.size() < 18 || rx_q[17] !== 8'h7A) bad++;
    n_checks++;
    if (rx_q.size() != 18 || bad != 0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_order: got %0d frames, %0d wrong, ovf=%b expected 18, 0, 0", rx_q.size(), bad, overflow);
    end
  endtask

  task test_reset_midframe;
    int lows, busys;
    do_reset();
    tick_en = 1;
    push = 1;
    push_data = 8'h53;
    @(negedge clk);
    push_data = 8'h57;
    @(negedge clk);
    push = 0;
    repeat (300) @(negedge clk);
    n_checks++;
    if ({tx_busy, tx} !== 2'b10) begin
      n_fail++;
      $display("FAIL pre_abort: busy,tx=%b expected 10", {tx_busy, tx});
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if ({tx, tx_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL async_abort: tx,busy=%b expected 10", {tx, tx_busy});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    rx_q.delete();
    n_checks++;
    if ({empty, overflow, full} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_flags: empty,ovf,full=%b expected 100", {empty, overflow, full});
    end
    lows = 0;
    busys = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
    end
    n_checks++;
    if (lows != 0 || busys != 0 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: %0d low, %0d busy samples, %0d frames expected 0 0 0", lows, busys, rx_q.size());
    end
  endtask

`ifdef TIME_UART_PARITY_EN
  task test_parity;
    do_reset();
    tick_en = 1;
    push = 1;
    push_data = 8'h53;
    @(negedge clk);
    push_data = 8'h57;
    @(negedge clk);
    push = 0;
    for (int c = 0; c < 2000 && rx_q.size() < 2; c++) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h53 || rx_q[1] !== 8'h57 || rxp_q[0] !== 1'b0 || rxp_q[1] !== 1'b1 || frame_err != 0) begin
      n_fail++;
      $display("FAIL parity: frames %0d, parity %b%b, stop errors %0d expected 2, 01, 0", rx_q.size(),
               rxp_q.size() > 0 ? rxp_q[0] : 1'bx, rxp_q.size() > 1 ? rxp_q[1] : 1'bx, frame_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_frames();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
`ifdef TIME_UART_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/time_uart_tx.md
Name: time_uart_tx

Overview:
- Downstream stage of the time-to-ASCII byte stream. It accepts ASCII bytes such as the 12-character "SW HH:MM:SS\n" / "CL HH:MM:SS\n" frames, one byte per push strobe.
- Bytes are buffered in a small synchronous FIFO.
- Each byte is serialized as UART 8N1, LSB first, paced by an external 16x-oversampled baud tick.
- The block sits between the ASCII formatter and the board TX pin.

Parameters:
- DATA_WIDTH, 8, width of each character and of the FIFO word.
- ADDR_WIDTH, 4, FIFO address width. Depth = 2**ADDR_WIDTH = 16 entries.
- OVERSAMPLE, 16, baud_tick pulses per UART bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  one-cycle strobe: write push_data into the FIFO.
- push_data  input  DATA_WIDTH  ASCII byte to transmit.
- baud_tick  input  1  one-cycle strobe at OVERSAMPLE x baud rate.
- full  output  1  FIFO holds 2**ADDR_WIDTH entries.
- empty  output  1  FIFO holds 0 entries.
- overflow  output  1  sticky: a push was dropped.
- tx  output  1  serial line, idle high, registered.
- tx_busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst=1): tx=1, tx_busy=0, full=0, empty=1, overflow=0. Pointers, count and state clear; FSM goes to IDLE. A reset mid-frame aborts the frame, and tx returns high immediately (asynchronously). Buffered bytes are discarded.
- FIFO: registered pointers, count width ADDR_WIDTH+1; full and empty are decoded from count and are registered.
  - push with !full: byte is written at wr_ptr; wr_ptr wraps modulo depth.
  - push with full and no pop in the same cycle: byte is dropped; overflow set to 1 at the next edge and held until rst.
  - push and pop in the same cycle with full: both succeed, count unchanged, overflow not set.
  - push and pop in the same cycle with empty: cannot occur, because pop requires !empty.
- Pop: occurs only in IDLE with !empty. It reads at rd_ptr into a DATA_WIDTH shift register. rd_ptr wraps.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !empty, pop and go to START at the same edge; tx registered low at that edge.
  - START: tx=0. Count baud_tick; on the OVERSAMPLE-th tick go to DATA with bit_idx=0.
  - DATA: tx=shift[0]. On the OVERSAMPLE-th tick, shift right. If bit_idx==DATA_WIDTH-1, go to STOP; else increment bit_idx.
  - STOP: tx=1. On the OVERSAMPLE-th tick go to IDLE. If the FIFO is non-empty, the next pop happens in the first IDLE cycle, giving a 1-clock gap between frames.
- Tick counter: cleared on every state transition. baud_tick is ignored in IDLE.
- Latency: push at edge N into an empty FIFO with FSM in IDLE gives empty=0 after edge N, pop at edge N+1, and tx low after edge N+1.
- Bit period: exactly OVERSAMPLE baud_ticks per bit, counted from the first tick after entering the state. The first bit may be up to one tick-interval longer.
- Ordering: bytes leave in push order, with no duplication or loss unless dropped on overflow.

Optional Feature:
- Macro TIME_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, lasting OVERSAMPLE ticks. tx = even parity, i.e. the XOR of the 8 data bits. Frame becomes 8E1, 11 bits.
- Undefined: no PARITY state, frame is 8N1, 10 bits. The PARITY state logic is not synthesized.

Test Plan:
- Push 0x53 ('S') once, baud_tick every 4 clk -> tx sequence 0 | 1,1,0,0,1,0,1,0 | 1, each bit exactly 16 ticks (64 clk) after the first bit. tx_busy=1 for the whole frame, then 0. empty=0 for 1 cycle after push.
- Push the 12 bytes "SW 12:34:56\n" (0x53 0x57 0x20 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x0A) on consecutive cycles -> 12 frames decoded in that order, full never asserted, overflow=0, empty=1 after the 12th pop.
- Push 17 bytes 0x41..0x51 on consecutive cycles with baud_tick held at 0 -> 1 byte popped into the shifter and 16 buffered, full=1. A further push of 0x52 is dropped, overflow=1 sticky. Decoded output is 0x41..0x51 only.
- With full=1 and the FSM in IDLE, push 0x7A in the same cycle as the pop -> count unchanged, overflow stays 0, 0x7A is transmitted last.
- Assert rst during the DATA state of a frame -> tx=1 and tx_busy=0 immediately. After release, empty=1, overflow=0, and no further frames are sent.
- With TIME_UART_PARITY_EN: push 0x53 -> parity bit 0. Push 0x57 (five ones) -> parity bit 1. Each frame is 11 bits.
